// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add/subtract sequencer. Two WIDTH-bit operands are latched on an
// accepted start request and pushed LSB first, one bit pair per clock, through
// a single 1-bit full adder (fulladder_new). Sum bits are shifted back into a
// result register from the top. When all bits have been processed the result,
// final carry and signed overflow are published together with a one-cycle
// done pulse. This is the minimal-area add path of the CPU datapath ALU.
//
// Subtraction is a + ~b + 1: B is inverted at load time and the carry register
// is preloaded with 1. For subtraction c_out=1 therefore means "no borrow".
//
// Optional feature (macro SERIAL_ADD_ZERO_FLAG_EN):
//   Adds output 'zero', set with sum when the result is all zeros. It is
//   accumulated serially as a sticky OR of the adder sum bit.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  bit-counter width
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   sub       in   0: a+b, 1: a-b (sampled with start)
//   a         in   operand A (sampled with start)
//   b         in   operand B (sampled with start)
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse when sum/c_out/overflow are updated
//   sum       out  result, held until the next completed operation
//   c_out     out  final carry out
//   overflow  out  signed overflow of the final result
//   zero      out  result == 0 (only with SERIAL_ADD_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------

// 1-bit full adder used as the serial arithmetic element.
module fulladder_new (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic w_p;

    assign w_p   = x ^ y;
    assign s     = w_p ^ c_in;
    assign c_out = (x & y) | (c_in & w_p);

endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_msb_cin;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_done;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    logic             r_nz;
    logic             r_zero;
`endif

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_fa_s;
    logic       w_fa_c;
    logic       w_last;
    logic       w_accept;

    assign w_last   = (r_cnt == LastBit);
    assign w_accept = (r_state == StIdle) && start;

    fulladder_new u_fa (
        .x     (r_op_a[0]),
        .y     (r_op_b[0]),
        .c_in  (r_carry),
        .s     (w_fa_s),
        .c_out (w_fa_c)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            // DONE always returns to IDLE; start is not looked at here.
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Serial datapath: operand shifters, carry, bit counter, result shifter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_msb_cin <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_op_a  <= a;
                r_op_b  <= sub ? ~b : b;
                // Carry-in of 1 completes the two's complement of B.
                r_carry <= sub;
                r_cnt   <= '0;
            end else if (r_state == StShift) begin
                r_op_a  <= r_op_a >> 1;
                r_op_b  <= r_op_b >> 1;
                r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                r_carry <= w_fa_c;
                r_cnt   <= r_cnt + 1'b1;
                // Carry into the MSB, needed for signed overflow detection.
                if (w_last) begin
                    r_msb_cin <= r_carry;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result publication. Outputs only change when an operation completes, so
    // the previous result stays visible while the next one is being computed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == StDone) begin
                r_sum   <= r_res;
                r_c_out <= r_carry;
                r_ovf   <= r_msb_cin ^ r_carry;
                r_done  <= 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_ZERO_FLAG_EN
    // Sticky OR of every produced sum bit; result is zero iff none was set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nz <= 1'b0;
            end else if (r_state == StShift) begin
                r_nz <= r_nz | w_fa_s;
            end
            if (r_state == StDone) begin
                r_zero <= ~r_nz;
            end
        end
    end

    assign zero = r_zero;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (r_state == StShift);
    assign done     = r_done;
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl (WIDTH=8). Expected results are pushed to
// a scoreboard queue when an operation is started and popped when done rises.
// Build with SERIAL_ADD_ZERO_FLAG_EN defined to also check the zero flag.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        logic             z;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    logic             zero;
`endif

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    serial_add_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
`ifdef SERIAL_ADD_ZERO_FLAG_EN
        .zero     (zero),
`endif
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pre-edge values are sampled here, so each count covers one full cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent arithmetic reference for randomised operations.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t             m;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] yy;
        yy  = s ? ~y : y;
        r   = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
        m.s = r[WIDTH-1:0];
        m.c = r[WIDTH];
        m.v = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        m.z = (r[WIDTH-1:0] == '0);
        return m;
    endfunction

    // Drive one start pulse from IDLE; returns acceptance cycle and busy count.
    task automatic start_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                            input logic xs, output int t_acc, output int b0);
        @(negedge clk);
        start = 1'b1;
        a     = xa;
        b     = xb;
        sub   = xs;
        b0    = busy_cnt;
        @(negedge clk);
        t_acc = cyc;
        start = 1'b0;
        // Operands may change freely once accepted.
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        sub   = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.s));
            check({tag, "_c_out"}, 32'(c_out), 32'(e.c));
            check({tag, "_overflow"}, 32'(overflow), 32'(e.v));
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            check({tag, "_zero"}, 32'(zero), 32'(e.z));
`endif
        end
    endtask

    task automatic wait_result(input string tag, input int t_acc, input int b0);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, 32'(cyc - t_acc), 32'(WIDTH + 1));
            check({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(WIDTH));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            compare_result(tag);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] xa,
                          input logic [WIDTH-1:0] xb, input logic xs, input exp_t e);
        int t_acc;
        int b0;
        q.push_back(e);
        start_op(xa, xb, xs, t_acc, b0);
        wait_result(tag, t_acc, b0);
    endtask

    initial begin
        int   t_acc;
        int   b0;
        int   d0;
        int   t_done[$];
        exp_t e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef SERIAL_ADD_ZERO_FLAG_EN
        check("rst_zero", 32'(zero), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain additions, including carry-out and signed overflow.
        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, '{s: 8'h7F, c: 1'b0, v: 1'b0, z: 1'b0});
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, '{s: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1});
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, '{s: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0});

        // Subtractions: borrow and signed overflow.
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, '{s: 8'hF0, c: 1'b0, v: 1'b0, z: 1'b0});
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, '{s: 8'h7F, c: 1'b1, v: 1'b1, z: 1'b0});

        // Start while busy is ignored; exactly one done for the accepted op.
        q.push_back('{s: 8'h03, c: 1'b0, v: 1'b0, z: 1'b0});
        d0 = done_cnt;
        start_op(8'h01, 8'h02, 1'b0, t_acc, b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore_busy_start", t_acc, b0);
        repeat (4) @(negedge clk);
        check("ignore_busy_done_count", 32'(done_cnt - d0), 32'd1);
        check("ignore_busy_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back operations with a WIDTH+2 period.
        q.push_back('{s: 8'h33, c: 1'b0, v: 1'b0, z: 1'b0});
        q.push_back('{s: 8'h33, c: 1'b0, v: 1'b0, z: 1'b0});
        @(negedge clk);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        sub   = 1'b0;
        for (int i = 0; i < 60 && t_done.size() < 2; i++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(cyc);
                compare_result("b2b");
                if (t_done.size() == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_two_dones", 32'(t_done.size()), 32'd2);
        if (t_done.size() == 2) begin
            check("b2b_period", 32'(t_done[1] - t_done[0]), 32'(WIDTH + 2));
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("b2b_no_third_busy", 32'(busy), 32'd0);

        // Asynchronous reset on the 4th busy cycle aborts with no done.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (WIDTH + 6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        // Equal-operand subtraction gives zero; off-by-one gives one.
        run_op("sub_05_05", 8'h05, 8'h05, 1'b1, '{s: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1});
        run_op("sub_06_05", 8'h06, 8'h05, 1'b1, '{s: 8'h01, c: 1'b1, v: 1'b0, z: 1'b0});

        // Randomised operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            e  = model(ra, rb, rs);
            run_op("rand", ra, rb, rs, e);
        end

        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
